mem_bus_if: RTL and testbench



---
 rtl/mem_bus_if.sv | 214 +++++++++++++++++++++
 tb/tb_mem_bus_if.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_if.sv
// ---------------------------------------------------------------------------
// mem_bus_if
// Bus interface between one pipeline stage (fetch or load/store) and its two
// memory targets. An access whose index field equals SPM_IDX goes straight to
// the scratchpad with no stall. Any other access runs a request/grant/ready
// handshake with the bus arbiter and holds busy until it completes.
//
// Optional feature: define MEM_BUS_IF_TIMEOUT_EN to add a bus timeout counter
// and the sticky err output.
//
// Ports
//   clk, reset_          clock, asynchronous active-low reset
//   stall, flush         pipeline control
//   busy                 access in progress (requester holds its request)
//   addr/as_/rw/wr_data  requester address, strobe (low), dir (1=rd), data
//   rd_data              read data returned to the requester
//   spm_*                scratchpad port (addr, strobe, dir, data in/out)
//   bus_*                system bus port (req/grant/ready, addr, strobe, data)
//   err                  sticky timeout flag (only with MEM_BUS_IF_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module mem_bus_if #(
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SPM_ADDR_W  = 12,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned SPM_IDX     = 3,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              stall,
    input  logic              flush,
    output logic              busy,
    input  logic [ADDR_W-1:0] addr,
    input  logic              as_,
    input  logic              rw,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] spm_rd_data,
    output logic [SPM_ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_,
    input  logic              bus_grnt_,
    output logic              bus_req_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data
`ifdef MEM_BUS_IF_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    localparam int unsigned CNT_W = 8;

    // The timeout counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 255) begin : g_tmo_range
        $error("mem_bus_if: TIMEOUT_CYC must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_STALL  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_bus_req_, w_bus_req_nxt;
    logic              r_bus_as_, w_bus_as_nxt;
    logic              r_bus_rw, w_bus_rw_nxt;
    logic [ADDR_W-1:0] r_bus_addr, w_bus_addr_nxt;
    logic [DATA_W-1:0] r_bus_wr_data, w_bus_wr_data_nxt;
    logic [DATA_W-1:0] r_rd_buf, w_rd_buf_nxt;
    logic              w_spm_hit;
    logic              w_start;
    logic [DATA_W-1:0] w_bus_rd_ret;

`ifdef MEM_BUS_IF_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYC);
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_err, w_err_nxt;
    assign err = r_err;
`endif

    // Scratchpad port is a straight pass-through apart from the strobe.
    assign spm_addr    = addr[SPM_ADDR_W-1:0];
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;

    assign bus_req_    = r_bus_req_;
    assign bus_as_     = r_bus_as_;
    assign bus_rw      = r_bus_rw;
    assign bus_addr    = r_bus_addr;
    assign bus_wr_data = r_bus_wr_data;

    assign w_spm_hit = (addr[ADDR_W-1 -: IDX_W] == IDX_W'(SPM_IDX));
    assign w_start   = (r_state == ST_IDLE) && !as_ && !flush && !w_spm_hit;

    // Writes return nothing, so the returned/buffered word is zero for them.
    assign w_bus_rd_ret = r_bus_rw ? bus_rd_data : '0;

    // Next-state, next-register and combinational output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_bus_req_nxt     = r_bus_req_;
        w_bus_as_nxt      = r_bus_as_;
        w_bus_rw_nxt      = r_bus_rw;
        w_bus_addr_nxt    = r_bus_addr;
        w_bus_wr_data_nxt = r_bus_wr_data;
        w_rd_buf_nxt      = r_rd_buf;
        busy              = 1'b0;
        rd_data           = '0;
        spm_as_           = 1'b1;
`ifdef MEM_BUS_IF_TIMEOUT_EN
        w_cnt_nxt         = r_cnt;
        w_err_nxt         = r_err;
`endif
        case (r_state)
            ST_IDLE: begin
                rd_data = spm_rd_data;
                if (w_start) begin
                    busy              = 1'b1;
                    rd_data           = '0;
                    w_state_nxt       = ST_REQ;
                    w_bus_req_nxt     = 1'b0;
                    w_bus_addr_nxt    = addr;
                    w_bus_rw_nxt      = rw;
                    w_bus_wr_data_nxt = wr_data;
`ifdef MEM_BUS_IF_TIMEOUT_EN
                    w_cnt_nxt         = '0;
`endif
                end else if (!as_ && !flush && !stall && w_spm_hit) begin
                    spm_as_ = 1'b0;
                end
            end
            ST_REQ: begin
                busy = 1'b1;
                if (!bus_grnt_) begin
                    w_bus_as_nxt = 1'b0;
                    w_state_nxt  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy         = 1'b1;
                w_bus_as_nxt = 1'b1;
                if (!bus_rdy_) begin
                    busy          = 1'b0;
                    rd_data       = w_bus_rd_ret;
                    w_rd_buf_nxt  = w_bus_rd_ret;
                    w_bus_req_nxt = 1'b1;
                    w_state_nxt   = stall ? ST_STALL : ST_IDLE;
                end
            end
            ST_STALL: begin
                rd_data = r_rd_buf;
                if (!stall) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
`ifdef MEM_BUS_IF_TIMEOUT_EN
        // Timeout overrides whatever the bus is doing in that cycle.
        if (r_state == ST_REQ || r_state == ST_ACCESS) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == TMO_LIM) begin
                busy          = 1'b0;
                rd_data       = DATA_W'(32'hDEAD_BEEF);
                w_bus_req_nxt = 1'b1;
                w_bus_as_nxt  = 1'b1;
                w_err_nxt     = 1'b1;
                w_state_nxt   = ST_IDLE;
            end
        end
`endif
    end

    // State and bus-side registers.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state       <= ST_IDLE;
            r_bus_req_    <= 1'b1;
            r_bus_as_     <= 1'b1;
            r_bus_rw      <= 1'b1;
            r_bus_addr    <= '0;
            r_bus_wr_data <= '0;
            r_rd_buf      <= '0;
`ifdef MEM_BUS_IF_TIMEOUT_EN
            r_cnt         <= '0;
            r_err         <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_bus_req_    <= w_bus_req_nxt;
            r_bus_as_     <= w_bus_as_nxt;
            r_bus_rw      <= w_bus_rw_nxt;
            r_bus_addr    <= w_bus_addr_nxt;
            r_bus_wr_data <= w_bus_wr_data_nxt;
            r_rd_buf      <= w_rd_buf_nxt;
`ifdef MEM_BUS_IF_TIMEOUT_EN
            r_cnt         <= w_cnt_nxt;
            r_err         <= w_err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_if.sv
// Testbench for mem_bus_if: drives transactions cycle by cycle from a
// timeline (grant delay, ready delay, stall length) and derives the expected
// outputs of every cycle from that timeline; one process compares.
module tb_mem_bus_if;

    logic        clk = 1'b0;
    logic        reset_;
    logic        stall, flush, as_, rw, bus_rdy_, bus_grnt_;
    logic [29:0] addr;
    logic [31:0] wr_data, spm_rd_data, bus_rd_data;
    logic        busy, spm_as_, spm_rw, bus_req_, bus_as_, bus_rw;
    logic [31:0] rd_data, spm_wr_data, bus_wr_data;
    logic [11:0] spm_addr;
    logic [29:0] bus_addr;
`ifdef MEM_BUS_IF_TIMEOUT_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    mem_bus_if dut (
        .clk(clk), .reset_(reset_), .stall(stall), .flush(flush), .busy(busy),
        .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data), .rd_data(rd_data),
        .spm_rd_data(spm_rd_data), .spm_addr(spm_addr), .spm_as_(spm_as_),
        .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_),
        .bus_req_(bus_req_), .bus_addr(bus_addr), .bus_as_(bus_as_),
        .bus_rw(bus_rw), .bus_wr_data(bus_wr_data)
`ifdef MEM_BUS_IF_TIMEOUT_EN
        , .err(err)
`endif
    );

    // Expected outputs for the current cycle.
    logic        e_busy, e_spm_as, e_req, e_bas, e_brw, e_spm_rw, e_err;
    logic [31:0] e_rd, e_bwd, e_spm_wd;
    logic [29:0] e_baddr;
    logic [11:0] e_spm_addr;
    // What the bus side has latched from the last started access.
    logic [29:0] m_baddr;
    logic        m_brw, m_err;
    logic [31:0] m_bwd;

    int n_chk = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always begin
        @(negedge clk or negedge reset_);
        #1;
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(e_busy));
            chk("rd_data", 64'(rd_data), 64'(e_rd));
            chk("spm_as_", 64'(spm_as_), 64'(e_spm_as));
            chk("spm_addr", 64'(spm_addr), 64'(e_spm_addr));
            chk("spm_rw", 64'(spm_rw), 64'(e_spm_rw));
            chk("spm_wr_data", 64'(spm_wr_data), 64'(e_spm_wd));
            chk("bus_req_", 64'(bus_req_), 64'(e_req));
            chk("bus_as_", 64'(bus_as_), 64'(e_bas));
            chk("bus_addr", 64'(bus_addr), 64'(e_baddr));
            chk("bus_rw", 64'(bus_rw), 64'(e_brw));
            chk("bus_wr_data", 64'(bus_wr_data), 64'(e_bwd));
`ifdef MEM_BUS_IF_TIMEOUT_EN
            chk("err", 64'(err), 64'(e_err));
`endif
        end
    end

    function automatic logic is_hit(input logic [29:0] a);
        return a[29:27] == 3'd3;
    endfunction

    // Expectations that follow directly from the driven inputs / latched model.
    task automatic set_base_exp();
        e_spm_addr = addr[11:0];
        e_spm_rw   = rw;
        e_spm_wd   = wr_data;
        e_spm_as   = 1'b1;
        e_baddr    = m_baddr;
        e_brw      = m_brw;
        e_bwd      = m_bwd;
        e_err      = m_err;
    endtask

    // One idle cycle that must not start a bus access.
    task automatic idle_cyc(input logic [29:0] a, input logic asn, input logic r,
                            input logic [31:0] wd, input logic fl, input logic st,
                            input logic [31:0] sd);
        @(posedge clk); #1;
        addr = a; as_ = asn; rw = r; wr_data = wd; flush = fl; stall = st;
        spm_rd_data = sd; bus_grnt_ = 1'($urandom); bus_rdy_ = 1'($urandom);
        bus_rd_data = $urandom;
        set_base_exp();
        e_busy   = 1'b0;
        e_rd     = sd;
        e_req    = 1'b1;
        e_bas    = 1'b1;
        e_spm_as = !(!asn && !fl && !st && is_hit(a));
    endtask

    task automatic drive_start(input logic [29:0] a, input logic r, input logic [31:0] wd);
        @(posedge clk); #1;
        addr = a; as_ = 1'b0; rw = r; wr_data = wd; flush = 1'b0;
        stall = 1'($urandom); spm_rd_data = $urandom;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = $urandom;
        set_base_exp();
        e_busy = 1'b1; e_rd = '0; e_req = 1'b1; e_bas = 1'b1;
        m_baddr = a; m_brw = r; m_bwd = wd;
    endtask

    // g cycles without grant, then one cycle with grant.
    task automatic drive_req(input int g);
        for (int i = 0; i <= g; i++) begin
            @(posedge clk); #1;
            bus_grnt_ = (i == g) ? 1'b0 : 1'b1;
            bus_rdy_ = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
            spm_rd_data = $urandom; bus_rd_data = $urandom;
            set_base_exp();
            e_busy = 1'b1; e_rd = '0; e_req = 1'b0; e_bas = 1'b1;
        end
    endtask

    task automatic bus_txn(input logic [29:0] a, input logic r, input logic [31:0] wd,
                           input int g, input int rl, input int ns,
                           input logic [31:0] rdat);
        logic [31:0] ret;
        ret = r ? rdat : 32'h0;
        drive_start(a, r, wd);
        drive_req(g);
        for (int j = 0; j <= rl; j++) begin
            @(posedge clk); #1;
            bus_rdy_ = (j == rl) ? 1'b0 : 1'b1;
            bus_grnt_ = 1'($urandom); flush = 1'($urandom); spm_rd_data = $urandom;
            bus_rd_data = (j == rl) ? rdat : $urandom;
            stall = (j == rl) ? (ns > 0) : 1'($urandom);
            set_base_exp();
            e_req  = 1'b0;
            e_bas  = (j == 0) ? 1'b0 : 1'b1;
            e_busy = (j != rl);
            e_rd   = (j == rl) ? ret : 32'h0;
        end
        for (int k = 1; k <= ns; k++) begin
            @(posedge clk); #1;
            stall = (k < ns);
            bus_grnt_ = 1'($urandom); bus_rdy_ = 1'($urandom); flush = 1'($urandom);
            spm_rd_data = $urandom; bus_rd_data = $urandom;
            set_base_exp();
            e_busy = 1'b0; e_rd = ret; e_req = 1'b1; e_bas = 1'b1;
        end
    endtask

    task automatic rand_idle();
        logic [29:0] a;
        logic asn, fl;
        a = 30'($urandom);
        if ($urandom_range(1, 0) == 1) a[29:27] = 3'd3;
        asn = 1'($urandom);
        fl  = 1'($urandom);
        if (!asn && !fl && !is_hit(a)) fl = 1'b1;
        idle_cyc(a, asn, 1'($urandom), $urandom, fl, 1'($urandom), $urandom);
    endtask

    task automatic rand_txn();
        logic [29:0] a;
        a = 30'($urandom);
        if (is_hit(a)) a[29] = 1'b1;
        bus_txn(a, 1'($urandom), $urandom, $urandom_range(4, 0),
                $urandom_range(4, 0), $urandom_range(3, 0), $urandom);
    endtask

    task automatic reset_exp();
        m_baddr = '0; m_brw = 1'b1; m_bwd = '0; m_err = 1'b0;
        set_base_exp();
        e_busy = 1'b0; e_rd = '0; e_req = 1'b1; e_bas = 1'b1;
    endtask

    initial begin
        reset_ = 1'b0; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = 1'b1;
        addr = '0; wr_data = '0; spm_rd_data = '0; bus_rd_data = '0;
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
        reset_exp();
        #2 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_ = 1'b1;

        // Scratchpad read: strobe, no busy, no bus request; data next cycle.
        idle_cyc(30'h1800_0010, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        e_spm_as = 1'b0; e_spm_addr = 12'h010; e_busy = 1'b0; e_req = 1'b1;
        idle_cyc(30'h1800_0010, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'hA5A5_0001);
        e_rd = 32'hA5A5_0001;
        // Scratchpad hit while stalled: no strobe.
        idle_cyc(30'h1800_0020, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0);

        // Bus read: grant after 2 cycles, ready 3 cycles later.
        bus_txn(30'h0000_0040, 1'b1, 32'h0, 2, 3, 0, 32'h1234_5678);
        idle_cyc(30'h0000_0040, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        e_baddr = 30'h0000_0040; e_brw = 1'b1;

        // Bus write completing under stall.
        bus_txn(30'h0000_0100, 1'b0, 32'hCAFE_0001, 1, 1, 2, 32'hFFFF_FFFF);
        idle_cyc(30'h0000_0100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        e_bwd = 32'hCAFE_0001; e_brw = 1'b0;

        // Read completing with stall held for 3 cycles.
        bus_txn(30'h0000_0200, 1'b1, 32'h0, 0, 0, 3, 32'h8765_4321);

        // Flush together with a strobe in idle: nothing starts.
        idle_cyc(30'h0000_0040, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0077);
        idle_cyc(30'h1800_0004, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0078);

        // Reset in the middle of an access.
        drive_start(30'h0000_0300, 1'b1, 32'h0);
        drive_req(0);
        @(posedge clk); #1;
        bus_rdy_ = 1'b1;
        set_base_exp();
        e_busy = 1'b1; e_rd = '0; e_req = 1'b0; e_bas = 1'b0;
        #2;
        as_ = 1'b1; spm_rd_data = '0;
        reset_exp();
        reset_ = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset_ = 1'b1;

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(2, 0) == 0) rand_idle();
            else rand_txn();
        end

`ifdef MEM_BUS_IF_TIMEOUT_EN
        // Grant never arrives: timeout after the counter reaches 255.
        drive_start(30'h0000_0500, 1'b1, 32'h0);
        for (int i = 0; i <= 255; i++) begin
            @(posedge clk); #1;
            bus_grnt_ = 1'b1; bus_rdy_ = 1'($urandom);
            set_base_exp();
            e_bas = 1'b1; e_req = 1'b0;
            e_busy = (i != 255);
            e_rd = (i == 255) ? 32'hDEAD_BEEF : 32'h0;
        end
        m_err = 1'b1;
        idle_cyc(30'h0000_0500, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        e_err = 1'b1; e_req = 1'b1;
`endif

        for (int n = 0; n < 3; n++) rand_idle();
        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
